writeback_arb: RTL and testbench

- Parametrised multi-channel successor to the single-port writeback stage.
- Accepts completed instructions from NCH independent producer channels (e.g. ALU, LSU, MUL/DIV), each buffered in a per-channel FIFO.
- Retires one instruction per cycle through a registered register-file write port using round-robin arbitration.
- Drives the debug/retire trace; sits between the execute/memory back-ends and the regfile/ID bypass.

---
 rtl/writeback_arb.sv | 214 +++++++++++++++++++++
 tb/tb_writeback_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arb.sv
// writeback_arb
// Multi-channel writeback stage. Each producer channel feeds its own FIFO.
// A round-robin arbiter retires one buffered instruction per cycle into a
// registered register-file write port and a retire trace.
//
// Optional feature macro: WB_INSTRET_EN
//   defined   : 64-bit retire counter on instret_o
//   undefined : no counter flops, instret_o tied to 0
//
// Ports:
//   clk_i, rst_ni   clock / asynchronous active-low reset
//   flush_i         drop every buffered entry plus this cycle's push and grant
//   ch_valid_i      per-channel entry valid
//   ch_ready_o      per-channel FIFO not full (state only)
//   ch_rd_we_i      per-channel destination write enable
//   ch_rd_s_i       per-channel destination index, packed NCH*RW
//   ch_rd_v_i       per-channel result, packed NCH*XLEN
//   ch_pc_i         per-channel debug PC, packed NCH*XLEN
//   ch_instr_i      per-channel debug instruction, packed NCH*32
//   rf_we_o         registered regfile write enable (x0 suppressed)
//   rf_rd_s_o       registered regfile write index
//   rf_rd_v_o       registered regfile write data
//   ret_valid_o     one instruction retired this cycle
//   ret_ch_o        channel that retired
//   ret_pc_o        retired PC
//   ret_instr_o     retired instruction
//   instret_o       retire counter
module writeback_arb #(
    parameter int NCH   = 3,
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int RW    = 5,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic [NCH-1:0]      ch_valid_i,
    output logic [NCH-1:0]      ch_ready_o,
    input  logic [NCH-1:0]      ch_rd_we_i,
    input  logic [NCH*RW-1:0]   ch_rd_s_i,
    input  logic [NCH*XLEN-1:0] ch_rd_v_i,
    input  logic [NCH*XLEN-1:0] ch_pc_i,
    input  logic [NCH*32-1:0]   ch_instr_i,
    output logic                rf_we_o,
    output logic [RW-1:0]       rf_rd_s_o,
    output logic [XLEN-1:0]     rf_rd_v_o,
    output logic                ret_valid_o,
    output logic [CHW-1:0]      ret_ch_o,
    output logic [XLEN-1:0]     ret_pc_o,
    output logic [31:0]         ret_instr_o,
    output logic [63:0]         instret_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage, no reset needed: occupancy is tracked by count/pointers.
    logic            mem_we    [NCH][DEPTH];
    logic [RW-1:0]   mem_s     [NCH][DEPTH];
    logic [XLEN-1:0] mem_v     [NCH][DEPTH];
    logic [XLEN-1:0] mem_pc    [NCH][DEPTH];
    logic [31:0]     mem_instr [NCH][DEPTH];

    logic [PW-1:0]   wr_ptr [NCH];
    logic [PW-1:0]   rd_ptr [NCH];
    logic [CW-1:0]   count  [NCH];
    logic [CHW-1:0]  rr_ptr;

    logic [NCH-1:0]  rdy;
    logic [NCH-1:0]  nonempty;
    logic [NCH-1:0]  push;
    logic [NCH-1:0]  pop;
    logic            gnt_any;
    logic [CHW-1:0]  gnt_idx;

    logic            sel_we;
    logic [RW-1:0]   sel_s;
    logic [XLEN-1:0] sel_v;
    logic [XLEN-1:0] sel_pc;
    logic [31:0]     sel_instr;

    always_comb begin
        rdy      = '0;
        nonempty = '0;
        push     = '0;
        for (int c = 0; c < NCH; c++) begin
            rdy[c]      = (count[c] < CW'(DEPTH));
            nonempty[c] = (count[c] != '0);
            push[c]     = ch_valid_i[c] && rdy[c] && !flush_i;
        end
    end

    assign ch_ready_o = rdy;

    // First non-empty channel scanning upward from rr_ptr, wrapping at NCH.
    always_comb begin
        int k;
        k       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            k = (int'(rr_ptr) + i) % NCH;
            if (!gnt_any && nonempty[k[CHW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = k[CHW-1:0];
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int c = 0; c < NCH; c++) begin
            pop[c] = gnt_any && !flush_i && (gnt_idx == CHW'(c));
        end
    end

    assign sel_we    = mem_we[gnt_idx][rd_ptr[gnt_idx]];
    assign sel_s     = mem_s[gnt_idx][rd_ptr[gnt_idx]];
    assign sel_v     = mem_v[gnt_idx][rd_ptr[gnt_idx]];
    assign sel_pc    = mem_pc[gnt_idx][rd_ptr[gnt_idx]];
    assign sel_instr = mem_instr[gnt_idx][rd_ptr[gnt_idx]];

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) begin
                mem_we[c][wr_ptr[c]]    <= ch_rd_we_i[c];
                mem_s[c][wr_ptr[c]]     <= ch_rd_s_i[c*RW +: RW];
                mem_v[c][wr_ptr[c]]     <= ch_rd_v_i[c*XLEN +: XLEN];
                mem_pc[c][wr_ptr[c]]    <= ch_pc_i[c*XLEN +: XLEN];
                mem_instr[c][wr_ptr[c]] <= ch_instr_i[c*32 +: 32];
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else if (flush_i) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
                case ({push[c], pop[c]})
                    2'b10:   count[c] <= count[c] + CW'(1);
                    2'b01:   count[c] <= count[c] - CW'(1);
                    default: count[c] <= count[c];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (flush_i) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
        end
    end

    // Payload registers hold their last value; only valid/we clear when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ret_valid_o <= 1'b0;
            rf_we_o     <= 1'b0;
            rf_rd_s_o   <= '0;
            rf_rd_v_o   <= '0;
            ret_ch_o    <= '0;
            ret_pc_o    <= '0;
            ret_instr_o <= '0;
        end else if (flush_i || !gnt_any) begin
            ret_valid_o <= 1'b0;
            rf_we_o     <= 1'b0;
        end else begin
            ret_valid_o <= 1'b1;
            rf_we_o     <= sel_we && (sel_s != '0);
            rf_rd_s_o   <= sel_s;
            rf_rd_v_o   <= sel_v;
            ret_ch_o    <= gnt_idx;
            ret_pc_o    <= sel_pc;
            ret_instr_o <= sel_instr;
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    // Advances on the same edge that raises ret_valid_o; flush keeps the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_q <= '0;
        end else if (!flush_i && gnt_any) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`else
    assign instret_o = '0;
`endif

endmodule

// File: tb/tb_writeback_arb.sv
// Bench for writeback_arb: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_writeback_arb;

    localparam int NCH   = 3;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic        we;
        logic [4:0]  s;
        logic [31:0] v;
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic [2:0]  ch_valid_i;
    logic [2:0]  ch_ready_o;
    logic [2:0]  ch_rd_we_i;
    logic [14:0] ch_rd_s_i;
    logic [95:0] ch_rd_v_i;
    logic [95:0] ch_pc_i;
    logic [95:0] ch_instr_i;
    logic        rf_we_o;
    logic [4:0]  rf_rd_s_o;
    logic [31:0] rf_rd_v_o;
    logic        ret_valid_o;
    logic [1:0]  ret_ch_o;
    logic [31:0] ret_pc_o;
    logic [31:0] ret_instr_o;
    logic [63:0] instret_o;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_arb #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(32), .RW(5)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .ch_valid_i  (ch_valid_i),
        .ch_ready_o  (ch_ready_o),
        .ch_rd_we_i  (ch_rd_we_i),
        .ch_rd_s_i   (ch_rd_s_i),
        .ch_rd_v_i   (ch_rd_v_i),
        .ch_pc_i     (ch_pc_i),
        .ch_instr_i  (ch_instr_i),
        .rf_we_o     (rf_we_o),
        .rf_rd_s_o   (rf_rd_s_o),
        .rf_rd_v_o   (rf_rd_v_o),
        .ret_valid_o (ret_valid_o),
        .ret_ch_o    (ret_ch_o),
        .ret_pc_o    (ret_pc_o),
        .ret_instr_o (ret_instr_o),
        .instret_o   (instret_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t        q [3][$];
    int          m_rr = 0;
    int          m_sz [3];
    logic        e_valid = 1'b0;
    logic        e_we = 1'b0;
    logic [4:0]  e_s = '0;
    logic [31:0] e_v = '0;
    logic [31:0] e_pc = '0;
    logic [31:0] e_instr = '0;
    logic [1:0]  e_ch = '0;
    logic [63:0] e_instret = '0;

    task automatic model_step();
        int   g;
        ent_t e;
        ent_t n;
        if (!rst_ni) begin
            for (int c = 0; c < 3; c++) q[c].delete();
            m_rr = 0;
            e_valid = 0; e_we = 0; e_s = 0; e_v = 0; e_pc = 0; e_instr = 0; e_ch = 0;
            e_instret = 0;
            return;
        end
        for (int c = 0; c < 3; c++) m_sz[c] = q[c].size();
        if (flush_i) begin
            for (int c = 0; c < 3; c++) q[c].delete();
            m_rr = 0;
            e_valid = 0;
            e_we = 0;
            return;
        end
        g = -1;
        for (int i = 0; i < 3; i++)
            if (g < 0 && m_sz[(m_rr + i) % 3] > 0) g = (m_rr + i) % 3;
        if (g >= 0) begin
            e = q[g].pop_front();
            e_valid = 1;
            e_we = e.we && (e.s != 0);
            e_s = e.s; e_v = e.v; e_pc = e.pc; e_instr = e.instr;
            e_ch = 2'(g);
            m_rr = (g + 1) % 3;
`ifdef WB_INSTRET_EN
            e_instret = e_instret + 64'd1;
`endif
        end else begin
            e_valid = 0;
            e_we = 0;
        end
        for (int c = 0; c < 3; c++) begin
            if (ch_valid_i[c] && m_sz[c] < DEPTH) begin
                n.we    = ch_rd_we_i[c];
                n.s     = ch_rd_s_i[c*5 +: 5];
                n.v     = ch_rd_v_i[c*32 +: 32];
                n.pc    = ch_pc_i[c*32 +: 32];
                n.instr = ch_instr_i[c*32 +: 32];
                q[c].push_back(n);
            end
        end
    endtask

    initial forever begin
        @(posedge clk_i or negedge rst_ni);
        model_step();
    end

    // Compare process: outputs are stable at the falling edge.
    initial forever begin
        @(negedge clk_i);
        chk("ret_valid", 64'(ret_valid_o), 64'(e_valid));
        chk("rf_we", 64'(rf_we_o), 64'(e_we));
        chk("rf_rd_s", 64'(rf_rd_s_o), 64'(e_s));
        chk("rf_rd_v", 64'(rf_rd_v_o), 64'(e_v));
        chk("ret_pc", 64'(ret_pc_o), 64'(e_pc));
        chk("ret_instr", 64'(ret_instr_o), 64'(e_instr));
        chk("ret_ch", 64'(ret_ch_o), 64'(e_ch));
        chk("instret", instret_o, e_instret);
        if (rst_ni) begin
            for (int c = 0; c < 3; c++)
                chk($sformatf("ready%0d", c), 64'(ch_ready_o[c]), 64'(q[c].size() < DEPTH));
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [2:0] last_rdy;

    task automatic clear_in();
        flush_i    = 0;
        ch_valid_i = '0;
        ch_rd_we_i = '0;
        ch_rd_s_i  = '0;
        ch_rd_v_i  = '0;
        ch_pc_i    = '0;
        ch_instr_i = '0;
    endtask

    task automatic set_ch(input int c, input logic we, input logic [4:0] s,
                          input logic [31:0] v, input logic [31:0] pc, input logic [31:0] ins);
        ch_valid_i[c]         = 1'b1;
        ch_rd_we_i[c]         = we;
        ch_rd_s_i[c*5 +: 5]   = s;
        ch_rd_v_i[c*32 +: 32] = v;
        ch_pc_i[c*32 +: 32]   = pc;
        ch_instr_i[c*32 +: 32] = ins;
    endtask

    task automatic step();
        last_rdy = ch_ready_o;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_flush();
        clear_in();
        flush_i = 1;
        step();
        flush_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [1:0]  rr_ch [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [31:0] rr_v  [6] = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200,
                               32'h1000_0001, 32'h1000_0101, 32'h1000_0201};
    logic [63:0] ins0;
    int          pend [3];
    int          sq   [3];
    int          pend_tot;

    initial begin
        rst_ni = 0;
        clear_in();
        ch_valid_i = 3'b111;
        ch_rd_we_i = 3'b111;
        ch_rd_s_i  = 15'h7fff;
        ch_rd_v_i  = {3{32'h5555_aaaa}};
        repeat (3) @(negedge clk_i);
        // Reset: valids held high must not leak out
        chk("rst_valid", 64'(ret_valid_o), 64'd0);
        chk("rst_we", 64'(rf_we_o), 64'd0);
        chk("rst_rd_v", 64'(rf_rd_v_o), 64'd0);
        chk("rst_pc", 64'(ret_pc_o), 64'd0);
        chk("rst_instret", instret_o, 64'd0);
        rst_ni = 1;
        clear_in();
        chk("rel_ready", 64'(ch_ready_o), 64'h7);
        step();
        chk("idle_valid", 64'(ret_valid_o), 64'd0);

        // Single channel, 2-cycle latency
        set_ch(1, 1, 5'd5, 32'hDEAD_BEEF, 32'h100, 32'h0050_0293);
        step();
        clear_in();
        chk("lat_n1_valid", 64'(ret_valid_o), 64'd0);
        step();
        chk("single_valid", 64'(ret_valid_o), 64'd1);
        chk("single_we", 64'(rf_we_o), 64'd1);
        chk("single_s", 64'(rf_rd_s_o), 64'd5);
        chk("single_v", 64'(rf_rd_v_o), 64'hDEAD_BEEF);
        chk("single_ch", 64'(ret_ch_o), 64'd1);
        chk("single_pc", 64'(ret_pc_o), 64'h100);
        step();
        chk("single_after_valid", 64'(ret_valid_o), 64'd0);
        chk("single_hold_v", 64'(rf_rd_v_o), 64'hDEAD_BEEF);

        // Round robin: two entries per channel from rr_ptr=0
        do_flush();
        for (int r = 0; r < 2; r++) begin
            clear_in();
            for (int c = 0; c < 3; c++)
                set_ch(c, 1, 5'(c + 1), 32'h1000_0000 | 32'(c << 8) | 32'(r),
                       32'h2000 + 32'(c * 16 + r * 4), 32'h13 + 32'(c));
            step();
        end
        clear_in();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_ch%0d", i), 64'(ret_ch_o), 64'(rr_ch[i]));
            chk($sformatf("rr_v%0d", i), 64'(rf_rd_v_o), 64'(rr_v[i]));
            step();
        end
        chk("rr_done_valid", 64'(ret_valid_o), 64'd0);

        // Backpressure: all channels streaming, valids held until accepted
        do_flush();
        for (int c = 0; c < 3; c++) begin pend[c] = 6; sq[c] = 0; end
        pend_tot = 18;
        for (int cyc = 0; cyc < 60 && pend_tot > 0; cyc++) begin
            clear_in();
            for (int c = 0; c < 3; c++)
                if (pend[c] > 0)
                    set_ch(c, 1, 5'(8 + c * 4 + (sq[c] & 3)), 32'(c << 16) | 32'(sq[c]),
                           32'h4000 + 32'(c * 256 + sq[c] * 4), 32'h33 + 32'(sq[c]));
            step();
            for (int c = 0; c < 3; c++)
                if (ch_valid_i[c] && last_rdy[c]) begin
                    sq[c]++;
                    pend[c]--;
                    pend_tot--;
                end
            if (cyc == 4) chk("bp_ready_after5", 64'(ch_ready_o), 64'h1);
        end
        chk("bp_all_accepted", 64'(pend_tot), 64'd0);
        clear_in();
        repeat (20) step();

        // x0 write and no-write both retire without a regfile write
        set_ch(0, 1, 5'd0, 32'h1111_1111, 32'h300, 32'h0000_0013);
        step();
        clear_in();
        set_ch(0, 0, 5'd7, 32'h2222_2222, 32'h304, 32'h0000_0393);
        ins0 = instret_o;
        step();
        clear_in();
        chk("x0_valid", 64'(ret_valid_o), 64'd1);
        chk("x0_we", 64'(rf_we_o), 64'd0);
        chk("x0_s", 64'(rf_rd_s_o), 64'd0);
        step();
        chk("nowe_valid", 64'(ret_valid_o), 64'd1);
        chk("nowe_we", 64'(rf_we_o), 64'd0);
        chk("nowe_s", 64'(rf_rd_s_o), 64'd7);
`ifdef WB_INSTRET_EN
        chk("x0_instret_delta", instret_o - ins0, 64'd2);
`else
        chk("x0_instret_zero", instret_o, 64'd0);
`endif
        step();

        // Flush with five entries buffered
        do_flush();
        for (int r = 0; r < 2; r++) begin
            clear_in();
            for (int c = 0; c < 3; c++)
                set_ch(c, 1, 5'(20 + c), 32'hF000_0000 | 32'(c * 16 + r),
                       32'h5000 + 32'(c * 16 + r), 32'h6F);
            step();
        end
        clear_in();
        chk("pre_flush_valid", 64'(ret_valid_o), 64'd1);
        ins0 = instret_o;
        do_flush();
        chk("flush_valid", 64'(ret_valid_o), 64'd0);
        chk("flush_we", 64'(rf_we_o), 64'd0);
        chk("flush_ready", 64'(ch_ready_o), 64'h7);
        chk("flush_instret", instret_o, ins0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("flush_stale%0d", i), 64'(ret_valid_o), 64'd0);
        end

        // Asynchronous reset mid-operation
        for (int r = 0; r < 2; r++) begin
            clear_in();
            for (int c = 0; c < 3; c++)
                set_ch(c, 1, 5'(3 + c), 32'hC0DE_0000 | 32'(c * 16 + r),
                       32'h7000 + 32'(c * 16 + r), 32'hB3);
            step();
        end
        clear_in();
        #2;
        rst_ni = 0;
        #1;
        chk("arst_valid", 64'(ret_valid_o), 64'd0);
        chk("arst_we", 64'(rf_we_o), 64'd0);
        chk("arst_v", 64'(rf_rd_v_o), 64'd0);
        chk("arst_instret", instret_o, 64'd0);
        @(negedge clk_i);
        rst_ni = 1;
        step();
        chk("arst_ready", 64'(ch_ready_o), 64'h7);
        step();
        chk("arst_no_escape", 64'(ret_valid_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
